// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder producing {cout,sum} = a + b + cin, BITS_PER_CYCLE bits per clock, LSB first.
// Optional subtract mode (port sub) is built when the macro SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int K     = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % K) != 0)) begin : g_bad_cfg
        $error("serial_adder: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CW-1:0]      cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [K:0]         slice_d;
    logic [WIDTH-1:0]   sum_shift_d;
    logic [WIDTH-1:0]   b_load_d;
    logic               carry_load_d;

    // In subtract mode the operand B is inverted and the carry forced to 1 (two's complement).
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_d     = sub ? ~b : b;
    assign carry_load_d = sub ? 1'b1 : cin;
`else
    assign b_load_d     = b;
    assign carry_load_d = cin;
`endif

    // One K-bit adder slice working on the low bits of the operand shift registers.
    always_comb begin
        slice_d = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
    end

    if (K < WIDTH) begin : g_shift
        assign sum_shift_d = {slice_d[K-1:0], sum_q[WIDTH-1:K]};
    end else begin : g_full
        assign sum_shift_d = slice_d[K-1:0];
    end

    // Control FSM and datapath registers; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_load_d;
                        carry_q    <= carry_load_d;
                        cnt_q      <= {CW{1'b0}};
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> K;
                    b_q     <= b_q >> K;
                    carry_q <= slice_d[K];
                    sum_q   <= sum_shift_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        cout_q      <= slice_d[K];
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
